approx_mult_pipe: RTL and testbench

//  Parametrised, 3-stage pipelined unsigned WIDTHxWIDTH multiplier with a per-transaction exact/approximate mode.

---
 rtl/approx_mult_pipe_if.sv | 27 ++
 rtl/approx_mult_pipe.sv | 133 +++++++++++++
 tb/tb_approx_mult_pipe.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/approx_mult_pipe_if.sv
// Operand/result handshake bundle for approx_mult_pipe. The source/sink side uses the master modport.
interface approx_mult_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               mode_in;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p_out;
  logic               p_inexact;
  logic [CNT_W-1:0]   err_cnt;
  logic               cnt_clr;

  modport master (
    output in_valid, a_in, b_in, mode_in, out_ready, cnt_clr,
    input  in_ready, out_valid, p_out, p_inexact, err_cnt
  );

  modport slave (
    input  in_valid, a_in, b_in, mode_in, out_ready, cnt_clr,
    output in_ready, out_valid, p_out, p_inexact, err_cnt
  );
endinterface

// File: rtl/approx_mult_pipe.sv
// 3-stage unsigned multiplier with per-beat exact/PRO5-approximate mode and an inexact-result counter.
// Latency 3, 1 beat/cycle; all stages stall together while the output is held (in_ready = ~out_valid | out_ready).
module approx_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  approx_mult_pipe_if.slave pipe_if
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW) + 2;
  localparam int NG = WIDTH / 4;

  logic             adv;
  logic             s1_vld_q, s2_vld_q, s3_vld_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             mode_q;
  logic [CW-1:0]    col_d [PW];
  logic [CW-1:0]    col_q [PW];
  logic             err_d, err_q;
  logic [PW-1:0]    p_d, p_q;
  logic             inx_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign adv               = ~s3_vld_q | pipe_if.out_ready;
  assign pipe_if.in_ready  = adv;
  assign pipe_if.out_valid = s3_vld_q;
  assign pipe_if.p_out     = p_q;
  assign pipe_if.p_inexact = inx_q;
  assign pipe_if.err_cnt   = cnt_q;

  // Per-column weight-2^k counts after compression; couts of column k land in column k+1.
  always_comb begin : reduce
    logic [WIDTH-1:0] colv;
    logic [3:0]       x;
    logic [CW-1:0]    carry;
    logic [CW-1:0]    nxt_carry;
    logic             s, co;
    int               n, ng, c;
    colv      = '0;
    x         = '0;
    carry     = '0;
    nxt_carry = '0;
    s         = 1'b0;
    co        = 1'b0;
    n         = 0;
    ng        = 0;
    c         = 0;
    err_d     = 1'b0;
    for (int k = 0; k < PW; k++) begin
      colv = '0;
      n    = 0;
      for (int r = 0; r < WIDTH; r++) begin
        c = k - r;
        if (c >= 0 && c < WIDTH) begin
          colv[n] = a_q[c] & b_q[r];
          n       = n + 1;
        end
      end
      ng        = (mode_q && (k < APPROX_COLS)) ? n / 4 : 0;
      col_d[k]  = carry;
      nxt_carry = '0;
      for (int g = 0; g < NG; g++) begin
        if (g < ng) begin
          x         = colv[4*g +: 4];
          s         = (^x) | (&x);
          co        = ((x[0] | x[1]) & (x[2] | x[3])) | (x[0] & x[1]) | (x[2] & x[3]);
          col_d[k]  = col_d[k] + CW'(s);
          nxt_carry = nxt_carry + CW'(co);
          err_d     = err_d | (&x);
        end
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= 4 * ng && i < n) col_d[k] = col_d[k] + CW'(colv[i]);
      end
      carry = nxt_carry;
    end
  end

  always_comb begin
    p_d = '0;
    for (int k = 0; k < PW; k++) p_d = p_d + (PW'(col_q[k]) << k);
  end

  // A clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (pipe_if.cnt_clr)
      cnt_d = '0;
    else if (s3_vld_q && pipe_if.out_ready && inx_q && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      for (int k = 0; k < PW; k++) col_q[k] <= '0;
      err_q    <= 1'b0;
      p_q      <= '0;
      inx_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (adv) begin
        s1_vld_q <= pipe_if.in_valid;
        s2_vld_q <= s1_vld_q;
        s3_vld_q <= s2_vld_q;
        if (pipe_if.in_valid) begin
          a_q    <= pipe_if.a_in;
          b_q    <= pipe_if.b_in;
          mode_q <= pipe_if.mode_in;
        end
        if (s1_vld_q) begin
          col_q <= col_d;
          err_q <= err_d;
        end
        if (s2_vld_q) begin
          p_q   <= p_d;
          inx_q <= err_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe: directed scenarios plus randomized traffic against a behavioural model.
module tb_approx_mult_pipe;
  localparam int W  = 8;
  localparam int AC = 8;
  localparam int CW = 2;

  logic clk;
  logic rst_n;

  approx_mult_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(AC), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pipe_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [2*W-1:0] p;
    logic          x;
  } slot_t;

  slot_t          sl [3];
  logic [CW-1:0]  m_cnt;
  int             n_checks;
  int             n_pass;

  logic [2*W-1:0] obs_p;
  logic           obs_v, obs_x, obs_rdy;
  logic [CW-1:0]  obs_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Product minus 2^k for every group of four ones in an approximated column.
  function automatic void ref_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                                   output logic [2*W-1:0] p, output logic x);
    int unsigned prod;
    int unsigned err;
    bit          bits [$];
    prod = int'(a) * int'(b);
    err  = 0;
    if (m) begin
      for (int k = 0; k < AC; k++) begin
        bits.delete();
        for (int r = 0; r < W; r++)
          if (k - r >= 0 && k - r < W) bits.push_back(a[k-r] & b[r]);
        for (int g = 0; g + 4 <= bits.size(); g += 4)
          if (bits[g] && bits[g+1] && bits[g+2] && bits[g+3]) err += (1 << k);
      end
    end
    p = (2*W)'(prod - err);
    x = (err != 0);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      sl[i].v = 1'b0;
      sl[i].p = '0;
      sl[i].x = 1'b0;
    end
    m_cnt = '0;
  endtask

  task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic m, input logic ordy, input logic clr, output logic acc);
    logic           exp_rdy;
    logic [2*W-1:0] np;
    logic           nx;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.mode_in   = m;
    bus.out_ready = ordy;
    bus.cnt_clr   = clr;
    #1;
    exp_rdy = !sl[2].v || ordy;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check("out_valid", 32'(bus.out_valid), 32'(sl[2].v));
    check("err_cnt", 32'(bus.err_cnt), 32'(m_cnt));
    if (sl[2].v) begin
      check("p_out", 32'(bus.p_out), 32'(sl[2].p));
      check("p_inexact", 32'(bus.p_inexact), 32'(sl[2].x));
    end
    obs_p   = bus.p_out;
    obs_v   = bus.out_valid;
    obs_x   = bus.p_inexact;
    obs_rdy = bus.in_ready;
    obs_cnt = bus.err_cnt;
    acc = iv && exp_rdy;
    if (clr) m_cnt = '0;
    else if (sl[2].v && ordy && sl[2].x && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    if (exp_rdy) begin
      ref_mult(a, b, m, np, nx);
      sl[2]   = sl[1];
      sl[1]   = sl[0];
      sl[0].v = iv;
      sl[0].p = np;
      sl[0].x = nx;
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic ordy, input logic clr);
    logic dummy;
    cycle(1'b0, '0, '0, 1'b0, ordy, clr, dummy);
  endtask

  initial begin
    logic           acc;
    logic [W-1:0]   ta [6];
    logic [W-1:0]   tb [6];
    logic           tm [6];
    logic [2*W-1:0] p_hold;
    logic [W-1:0]   pa, pb;
    logic           pm, iv, ordy, clr;
    int             i;

    n_checks = 0;
    n_pass   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.mode_in   = 1'b0;
    bus.out_ready = 1'b0;
    bus.cnt_clr   = 1'b0;
    clear_model();

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_p_out", 32'(bus.p_out), 32'd0);
    check("rst_p_inexact", 32'(bus.p_inexact), 32'd0);
    check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    rst_n = 1'b1;

    // Exact beat: 211 * 206 = 43466.
    cycle(1'b1, 8'hD3, 8'hCE, 1'b0, 1'b1, 1'b0, acc);
    repeat (3) idle(1'b1, 1'b0);
    check("t1_valid", 32'(obs_v), 32'd1);
    check("t1_p", 32'(obs_p), 32'hA9CA);
    check("t1_inexact", 32'(obs_x), 32'd0);

    // All-ones operands: six saturated cells, error 376.
    cycle(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, acc);
    repeat (3) idle(1'b1, 1'b0);
    check("t2_p", 32'(obs_p), 32'd64649);
    check("t2_inexact", 32'(obs_x), 32'd1);
    idle(1'b1, 1'b0);
    check("t2_cnt", 32'(obs_cnt), 32'd1);

    cycle(1'b1, 8'h0F, 8'h01, 1'b1, 1'b1, 1'b0, acc);
    repeat (3) idle(1'b1, 1'b0);
    check("t3_p", 32'(obs_p), 32'h000F);
    check("t3_inexact", 32'(obs_x), 32'd0);
    idle(1'b1, 1'b0);
    check("t3_cnt", 32'(obs_cnt), 32'd1);

    // Back-to-back stream with the sink stalled for cycles 2..5.
    for (int k = 0; k < 6; k++) begin
      ta[k] = W'($urandom);
      tb[k] = W'($urandom | $urandom);
      tm[k] = 1'($urandom);
    end
    i = 0;
    for (int t = 0; t < 16; t++) begin
      ordy = !(t >= 2 && t <= 5);
      if (i < 6) cycle(1'b1, ta[i], tb[i], tm[i], ordy, 1'b0, acc);
      else       cycle(1'b0, '0, '0, 1'b0, ordy, 1'b0, acc);
      if (acc) i++;
      if (t == 3) p_hold = obs_p;
      if (t == 4) check("t4_stall_ready", 32'(obs_rdy), 32'd0);
      if (t == 5) check("t4_hold_p", 32'(obs_p), 32'(p_hold));
    end
    check("t4_all_sent", 32'(i), 32'd6);

    // Reset with the pipeline full.
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'hFF, 8'hF7, 1'b1, 1'b1, 1'b0, acc);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("t5_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_err_cnt", 32'(bus.err_cnt), 32'd0);
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) idle(1'b1, 1'b0);
    check("t5_no_stale", 32'(obs_v), 32'd0);

    // Randomized traffic with random sink stalls and occasional clears.
    pa = W'($urandom);
    pb = W'($urandom | $urandom);
    pm = 1'($urandom);
    for (int t = 0; t < 400; t++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 31) == 0);
      cycle(iv, pa, pb, pm, ordy, clr, acc);
      if (acc || !iv) begin
        pa = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom | $urandom | $urandom);
        pb = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom | $urandom | $urandom);
        pm = 1'($urandom);
      end
    end
    repeat (4) idle(1'b1, 1'b0);

    // Two-bit counter saturation, then clear against a coincident inexact delivery.
    idle(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) cycle(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, acc);
    repeat (4) idle(1'b1, 1'b0);
    check("t6_saturate", 32'(obs_cnt), 32'd3);
    cycle(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, acc);
    repeat (2) idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    check("t6_coincident", 32'(obs_x), 32'd1);
    idle(1'b1, 1'b0);
    check("t6_clear", 32'(obs_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
